// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - instruction-sequencing controller locked to the fetch/alu_ena frame
//
// Purpose: locks onto the 8-cycle phase frame of the clock generator, steps S0..S7 once
// per instruction and decodes the datapath strobes. Misaligned phase strobes drop the
// machine back to IDLE, pulse phase_err and bump a saturating error counter.
//
// Ports:
//   sys_clk      rising-edge clock
//   rst          synchronous active-high reset
//   fetch        phase strobe, high p0..p3
//   alu_ena      phase strobe, high p5 only
//   opcode[2:0]  IR opcode (HLT SKZ ADD AND XOR LDA STO JMP = 0..7)
//   zero         accumulator-zero flag
//   load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt   datapath strobes
//   phase_err    single-cycle phase-mismatch flag
//   err_cnt      saturating phase-error count

module cpu_ctrl_fsm #(
  parameter int CHECK_PHASE = 1,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 fetch,
  input  logic                 alu_ena,
  input  logic [2:0]           opcode,
  input  logic                 zero,
  output logic                 load_ir,
  output logic                 inc_pc,
  output logic                 load_pc,
  output logic                 load_acc,
  output logic                 rd,
  output logic                 wr,
  output logic                 datactl_ena,
  output logic                 halt,
  output logic                 phase_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [3:0] {
    IDLE, S0, S1, S2, S3, S4, S5, S6, S7, HALT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       fetch_d;
  logic [2:0] op_q;
  logic       zero_q;
  logic       rise;
  logic       phase_bad;
  logic       alu_op;

  assign rise   = fetch & ~fetch_d;
  assign alu_op = (op_q == OP_ADD) || (op_q == OP_AND) ||
                  (op_q == OP_XOR) || (op_q == OP_LDA);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= IDLE;
      fetch_d <= 1'b0;
      op_q    <= OP_HLT;
      zero_q  <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      fetch_d <= fetch;
      if (state == S2) op_q <= opcode;
      if (state == S3) zero_q <= zero;
      if (phase_bad && (err_cnt != {ERR_CNT_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
    end
  end

  // Phase check: each locked state expects a fixed fetch level (S7 expects the
  // rising edge of the next frame) and alu_ena only in S4.
  always_comb begin
    phase_bad = 1'b0;
    if (CHECK_PHASE != 0) begin
      case (state)
        S0, S1, S2: phase_bad = ~fetch | alu_ena;
        S3, S5, S6: phase_bad = fetch | alu_ena;
        S4:         phase_bad = fetch | ~alu_ena;
        S7:         phase_bad = ~rise | alu_ena;
        default:    phase_bad = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = S0;
      S0:      state_nxt = S1;
      S1:      state_nxt = S2;
      S2:      state_nxt = S3;
      S3:      state_nxt = (op_q == OP_HLT) ? HALT : S4;
      S4:      state_nxt = S5;
      S5:      state_nxt = S6;
      S6:      state_nxt = S7;
      S7:      state_nxt = S0;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
    // A misaligned frame outranks everything, including HLT in S3; relock
    // always waits for a fresh rise from IDLE.
    if (phase_bad) state_nxt = IDLE;
  end

  always_comb begin
    load_ir     = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    phase_err   = phase_bad;
    case (state)
      S0: begin
        rd      = 1'b1;
        load_ir = 1'b1;
      end
      S1: begin
        rd      = 1'b1;
        load_ir = 1'b1;
        inc_pc  = 1'b1;
      end
      S3: inc_pc = (op_q != OP_HLT);
      S4: begin
        rd          = alu_op;
        datactl_ena = (op_q == OP_STO);
        load_pc     = (op_q == OP_JMP);
      end
      S5: begin
        rd          = alu_op;
        load_acc    = alu_op;
        datactl_ena = (op_q == OP_STO);
        wr          = (op_q == OP_STO);
        load_pc     = (op_q == OP_JMP);
        inc_pc      = (op_q == OP_SKZ) & zero_q;
      end
      S6: datactl_ena = (op_q == OP_STO);
      S7: inc_pc = (op_q == OP_SKZ) & zero_q;
      HALT: halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - scoreboard bench for cpu_ctrl_fsm

module tb_cpu_ctrl_fsm;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       fetch = 1'b0;
  logic       alu_ena = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;

  logic       a_load_ir, a_inc_pc, a_load_pc, a_load_acc, a_rd, a_wr, a_datactl_ena, a_halt, a_phase_err;
  logic [7:0] a_err_cnt;
  logic       b_load_ir, b_inc_pc, b_load_pc, b_load_acc, b_rd, b_wr, b_datactl_ena, b_halt, b_phase_err;
  logic [7:0] b_err_cnt;

  always #5 sys_clk = ~sys_clk;

  cpu_ctrl_fsm #(.CHECK_PHASE(1), .ERR_CNT_W(8)) u_dut (
    .sys_clk(sys_clk), .rst(rst), .fetch(fetch), .alu_ena(alu_ena), .opcode(opcode), .zero(zero),
    .load_ir(a_load_ir), .inc_pc(a_inc_pc), .load_pc(a_load_pc), .load_acc(a_load_acc),
    .rd(a_rd), .wr(a_wr), .datactl_ena(a_datactl_ena), .halt(a_halt),
    .phase_err(a_phase_err), .err_cnt(a_err_cnt)
  );

  cpu_ctrl_fsm #(.CHECK_PHASE(0), .ERR_CNT_W(8)) u_dut_nochk (
    .sys_clk(sys_clk), .rst(rst), .fetch(fetch), .alu_ena(alu_ena), .opcode(opcode), .zero(zero),
    .load_ir(b_load_ir), .inc_pc(b_inc_pc), .load_pc(b_load_pc), .load_acc(b_load_acc),
    .rd(b_rd), .wr(b_wr), .datactl_ena(b_datactl_ena), .halt(b_halt),
    .phase_err(b_phase_err), .err_cnt(b_err_cnt)
  );

  localparam int ST_IDLE = -1;
  localparam int ST_HALT = 8;

  int         checks = 0;
  int         errors = 0;
  int         inc_cnt = 0;
  int         b_perr_seen = 0;
  logic [8:0] sb_q[$];

  int         m_st = ST_IDLE;
  logic [2:0] m_op = 3'd0;
  logic       m_zq = 1'b0;
  logic       m_fd = 1'b0;
  int         m_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {halt, phase_err, datactl_ena, wr, rd, load_acc, load_pc, inc_pc, load_ir}
  function automatic logic [8:0] exp_strobes(input int st, input logic [2:0] op, input logic zq, input logic perr);
    logic alu, sto, jmp, skz;
    logic [8:0] v;
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    sto = (op == 3'd6);
    jmp = (op == 3'd7);
    skz = (op == 3'd1);
    v = '0;
    v[7] = perr;
    case (st)
      0: begin v[4] = 1'b1; v[0] = 1'b1; end
      1: begin v[4] = 1'b1; v[0] = 1'b1; v[1] = 1'b1; end
      3: v[1] = (op != 3'd0);
      4: begin v[4] = alu; v[6] = sto; v[2] = jmp; end
      5: begin v[4] = alu; v[3] = alu; v[6] = sto; v[5] = sto; v[2] = jmp; v[1] = skz & zq; end
      6: v[6] = sto;
      7: v[1] = skz & zq;
      8: v[8] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [8:0] obs_strobes();
    return {a_halt, a_phase_err, a_datactl_ena, a_wr, a_rd, a_load_acc, a_load_pc, a_inc_pc, a_load_ir};
  endfunction

  // One frame cycle: predict, push, sample at the falling edge, pop, compare, advance model.
  task automatic cyc(input logic f, input logic a);
    logic rise, err;
    logic [8:0] got, want;
    fetch   = f;
    alu_ena = a;
    rise = f & ~m_fd;
    err = 1'b0;
    if (m_st >= 0 && m_st <= 7) begin
      if (m_st <= 2 && !f) err = 1'b1;
      if (m_st >= 3 && m_st <= 6 && f) err = 1'b1;
      if (m_st == 7 && !rise) err = 1'b1;
      if (a != (m_st == 4)) err = 1'b1;
    end
    sb_q.push_back(exp_strobes(m_st, m_op, m_zq, err));
    @(negedge sys_clk);
    got = obs_strobes();
    if (sb_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      want = sb_q.pop_front();
      check("strobes", int'(got), int'(want));
    end
    check("rd_wr_excl", int'(a_rd & a_wr), 0);
    if (b_phase_err) b_perr_seen++;
    if (a_inc_pc) inc_cnt++;
    if (m_st == 2) m_op = opcode;
    if (m_st == 3) m_zq = zero;
    if (err) begin
      if (m_cnt < 255) m_cnt++;
      m_st = ST_IDLE;
    end else if (m_st == ST_IDLE) begin
      if (rise) m_st = 0;
    end else if (m_st == 3 && m_op == 3'd0) begin
      m_st = ST_HALT;
    end else if (m_st >= 0 && m_st <= 7) begin
      m_st = (m_st + 1) % 8;
    end
    m_fd = f;
    @(posedge sys_clk);
    #1;
  endtask

  // One 8-cycle frame p0..p7; chk_inc >= 0 checks inc_pc pulses of the previous
  // instruction, whose S7 lands on this frame's p0.
  task automatic frame(input logic [2:0] op, input logic z, input int apos, input int flen, input int chk_inc);
    opcode = op;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      cyc(p < flen, p == apos);
      if (p == 0) begin
        if (chk_inc >= 0) check("inc_pc_pulses", inc_cnt, chk_inc);
        inc_cnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    fetch   = 1'b0;
    alu_ena = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    rst   = 1'b0;
    m_st  = ST_IDLE;
    m_op  = 3'd0;
    m_zq  = 1'b0;
    m_fd  = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    do_reset();
    check("reset_strobes", int'(obs_strobes()), 0);
    check("reset_err_cnt", int'(a_err_cnt), 0);

    frame(3'd2, 1'b0, 5, 4, -1);   // ADD
    frame(3'd6, 1'b0, 5, 4, 2);    // STO; ADD had inc_pc in S1,S3
    frame(3'd1, 1'b1, 5, 4, 2);    // SKZ zero=1
    frame(3'd1, 1'b0, 5, 4, 4);    // SKZ zero=0
    frame(3'd5, 1'b0, 5, 4, 2);    // LDA
    frame(3'd2, 1'b0, 6, 4, 2);    // alu_ena moved to p6
    check("err_cnt_one", int'(a_err_cnt), 1);
    frame(3'd7, 1'b0, 5, 4, -1);   // relock, JMP
    frame(3'd4, 1'b0, 5, 4, 2);    // XOR
    frame(3'd3, 1'b0, 5, 4, 2);    // AND

    for (int i = 0; i < 300; i++) frame(3'd2, 1'b0, 5, 3, -1);  // fetch low at p3
    check("err_cnt_sat", int'(a_err_cnt), 255);
    check("err_cnt_model", int'(a_err_cnt), m_cnt);

    frame(3'd2, 1'b0, 5, 4, -1);   // relock after the error storm
    frame(3'd0, 1'b0, 5, 4, 2);    // HLT
    frame(3'd2, 1'b0, 5, 4, 1);    // HLT instruction only pulsed inc_pc in S1
    frame(3'd2, 1'b0, 5, 4, 0);
    frame(3'd2, 1'b0, 5, 4, 0);
    check("halt_held", int'(a_halt), 1);

    do_reset();
    check("post_halt_strobes", int'(obs_strobes()), 0);
    check("post_halt_err_cnt", int'(a_err_cnt), 0);
    frame(3'd2, 1'b0, 5, 4, -1);
    frame(3'd2, 1'b0, 5, 4, 2);

    check("nochk_phase_err", b_perr_seen, 0);
    check("nochk_err_cnt", int'(b_err_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
